// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: program memory feeding a small
// {instruction, pc} queue, with branch redirect and fetch halt.
module prefetch_unit #(
  parameter int          IW       = 15,
  parameter int          AW       = 8,
  parameter int          DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                       CLK_FT,
  input  logic                       RESET_N,
  input  logic                       LD_EN,
  input  logic [AW-1:0]              LD_ADDR,
  input  logic [IW-1:0]              LD_DATA,
  input  logic                       HALT,
  input  logic                       REDIR,
  input  logic [AW-1:0]              REDIR_ADDR,
  input  logic                       INST_READY,
  output logic                       INST_VALID,
  output logic [IW-1:0]              INST_OUT,
  output logic [AW-1:0]              INST_PC,
  output logic [AW-1:0]              FETCH_PC,
  output logic [$clog2(DEPTH):0]     Q_COUNT
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [IW-1:0] r_mem    [2**AW];
  logic [IW-1:0] r_q_inst [DEPTH];
  logic [AW-1:0] r_q_pc   [DEPTH];

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_fetch_pc;

  logic w_valid;
  logic w_pop;
  logic w_issue;

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & INST_READY & ~REDIR;
  assign w_issue = ~HALT & ~LD_EN & ~REDIR &
                   ((r_count < CW'(DEPTH)) | w_pop);

  // Memory is deliberately outside reset so a program survives it
  always_ff @(posedge CLK_FT) begin
    if (LD_EN) r_mem[LD_ADDR] <= LD_DATA;
  end

  always_ff @(posedge CLK_FT) begin
    if (w_issue) begin
      r_q_inst[r_wr_ptr] <= r_mem[r_fetch_pc];
      r_q_pc[r_wr_ptr]   <= r_fetch_pc;
    end
  end

  always_ff @(posedge CLK_FT or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_fetch_pc <= AW'(RESET_PC);
    end else if (REDIR) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_fetch_pc <= REDIR_ADDR;
    end else begin
      if (w_issue) begin
        r_wr_ptr   <= r_wr_ptr + PW'(1);
        r_fetch_pc <= r_fetch_pc + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      unique case ({w_issue, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head fields are forced to zero while empty
  assign INST_VALID = w_valid;
  assign INST_OUT   = w_valid ? r_q_inst[r_rd_ptr] : '0;
  assign INST_PC    = w_valid ? r_q_pc[r_rd_ptr] : '0;
  assign FETCH_PC   = r_fetch_pc;
  assign Q_COUNT    = r_count;

endmodule

// File: tb/tb_prefetch_unit.sv
// Self-checking bench for prefetch_unit: scoreboard of issued
// {inst, pc} entries checked against the queue head every cycle.
module tb_prefetch_unit;

  localparam int IW = 15;
  localparam int AW = 8;
  localparam int DEPTH = 4;
  localparam int unsigned RST_PC = 0;

  typedef struct {
    logic [IW-1:0] inst;
    logic [AW-1:0] pc;
  } ent_t;

  logic          CLK_FT;
  logic          RESET_N;
  logic          LD_EN;
  logic [AW-1:0] LD_ADDR;
  logic [IW-1:0] LD_DATA;
  logic          HALT;
  logic          REDIR;
  logic [AW-1:0] REDIR_ADDR;
  logic          INST_READY;
  logic          INST_VALID;
  logic [IW-1:0] INST_OUT;
  logic [AW-1:0] INST_PC;
  logic [AW-1:0] FETCH_PC;
  logic [2:0]    Q_COUNT;

  logic [IW-1:0] m_mem [2**AW];
  logic [AW-1:0] m_fpc;
  ent_t          sb [$];

  int n_asserts = 0;
  int n_fail = 0;

  prefetch_unit #(
    .IW(IW), .AW(AW), .DEPTH(DEPTH), .RESET_PC(RST_PC)
  ) dut (
    .CLK_FT(CLK_FT),
    .RESET_N(RESET_N),
    .LD_EN(LD_EN),
    .LD_ADDR(LD_ADDR),
    .LD_DATA(LD_DATA),
    .HALT(HALT),
    .REDIR(REDIR),
    .REDIR_ADDR(REDIR_ADDR),
    .INST_READY(INST_READY),
    .INST_VALID(INST_VALID),
    .INST_OUT(INST_OUT),
    .INST_PC(INST_PC),
    .FETCH_PC(FETCH_PC),
    .Q_COUNT(Q_COUNT)
  );

  initial CLK_FT = 1'b0;
  always #5 CLK_FT = ~CLK_FT;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check();
    chk("q_count", 32'(Q_COUNT), 32'(sb.size()));
    chk("fetch_pc", 32'(FETCH_PC), 32'(m_fpc));
    chk("inst_valid", 32'(INST_VALID), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("inst_out", 32'(INST_OUT), 32'(sb[0].inst));
      chk("inst_pc", 32'(INST_PC), 32'(sb[0].pc));
    end else begin
      chk("inst_out_zero", 32'(INST_OUT), 32'(0));
      chk("inst_pc_zero", 32'(INST_PC), 32'(0));
    end
  endtask

  task automatic step();
    bit pop, iss;
    ent_t e;
    pop = (sb.size() != 0) && INST_READY && !REDIR;
    iss = !HALT && !LD_EN && !REDIR &&
          ((sb.size() < DEPTH) || pop);
    @(posedge CLK_FT);
    if (LD_EN) m_mem[LD_ADDR] = LD_DATA;
    if (!RESET_N) begin
      sb.delete();
      m_fpc = AW'(RST_PC);
    end else if (REDIR) begin
      sb.delete();
      m_fpc = REDIR_ADDR;
    end else begin
      if (pop) void'(sb.pop_front());
      if (iss) begin
        e.inst = m_mem[m_fpc];
        e.pc = m_fpc;
        sb.push_back(e);
        m_fpc = m_fpc + AW'(1);
      end
    end
    #1;
    check();
  endtask

  task automatic redir_to(input logic [AW-1:0] a);
    REDIR = 1'b1;
    REDIR_ADDR = a;
    step();
    REDIR = 1'b0;
  endtask

  initial begin
    RESET_N = 1'b0;
    LD_EN = 1'b0;
    LD_ADDR = '0;
    LD_DATA = '0;
    HALT = 1'b0;
    REDIR = 1'b0;
    REDIR_ADDR = '0;
    INST_READY = 1'b0;
    m_fpc = AW'(RST_PC);
    #1;
    check();

    // Load whole memory while held in reset
    LD_EN = 1'b1;
    for (int i = 0; i < 2**AW; i++) begin
      LD_ADDR = AW'(i);
      if (i == 0) LD_DATA = 15'h4800;
      else if (i == 1) LD_DATA = 15'h4000;
      else LD_DATA = IW'((i * 32'h123) ^ 32'h2A5);
      step();
    end
    LD_EN = 1'b0;
    RESET_N = 1'b1;

    // Stalled consumer: queue fills and holds
    for (int i = 0; i < 6; i++) step();
    chk("full_count", 32'(Q_COUNT), 32'd4);
    chk("full_fpc", 32'(FETCH_PC), 32'd4);
    chk("full_head_pc", 32'(INST_PC), 32'd0);
    chk("full_head_inst", 32'(INST_OUT), 32'h4800);

    // Redirect from full queue
    redir_to(8'h08);
    chk("redir_count", 32'(Q_COUNT), 32'd0);
    chk("redir_fpc", 32'(FETCH_PC), 32'h08);
    step();
    chk("redir_valid", 32'(INST_VALID), 32'd1);
    chk("redir_pc", 32'(INST_PC), 32'h08);

    // Streaming from 0
    INST_READY = 1'b1;
    redir_to(8'h00);
    for (int i = 0; i < 20; i++) step();

    // Fetch address wrap
    redir_to(8'hFE);
    step();
    step();
    chk("wrap_fpc", 32'(FETCH_PC), 32'h00);
    chk("wrap_pc_ff", 32'(INST_PC), 32'hFF);
    step();
    chk("wrap_pc_00", 32'(INST_PC), 32'h00);
    step();

    // Halt drains queue with frozen fetch pc
    INST_READY = 1'b0;
    redir_to(8'h10);
    for (int i = 0; i < 3; i++) step();
    chk("halt_pre_count", 32'(Q_COUNT), 32'd3);
    HALT = 1'b1;
    INST_READY = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("halt_fpc", 32'(FETCH_PC), 32'h13);
    chk("halt_valid", 32'(INST_VALID), 32'd0);
    HALT = 1'b0;

    // Random ready/halt traffic, including full+pop
    for (int i = 0; i < 40; i++) begin
      INST_READY = 1'($urandom_range(0, 1));
      HALT = ($urandom_range(0, 3) == 0);
      step();
    end
    HALT = 1'b0;

    // Load does not flush stale entries
    INST_READY = 1'b0;
    redir_to(8'h30);
    for (int i = 0; i < 4; i++) step();
    LD_EN = 1'b1;
    LD_ADDR = 8'h31;
    LD_DATA = 15'h7ABC;
    step();
    LD_EN = 1'b0;
    INST_READY = 1'b1;
    step();
    chk("stale_pc", 32'(INST_PC), 32'h31);
    chk("stale_inst", 32'(INST_OUT), 32'(m_mem[8'h32] ^ m_mem[8'h32]
        ^ IW'((32'h31 * 32'h123) ^ 32'h2A5)));

    // Redirect and load together
    REDIR = 1'b1;
    REDIR_ADDR = 8'h31;
    LD_EN = 1'b1;
    LD_ADDR = 8'h31;
    LD_DATA = 15'h1234;
    step();
    REDIR = 1'b0;
    LD_EN = 1'b0;
    step();
    chk("redld_pc", 32'(INST_PC), 32'h31);
    chk("redld_inst", 32'(INST_OUT), 32'h1234);
    step();

    // Asynchronous reset mid-operation
    INST_READY = 1'b0;
    redir_to(8'h20);
    step();
    step();
    chk("prerst_count", 32'(Q_COUNT), 32'd2);
    RESET_N = 1'b0;
    #1;
    sb.delete();
    m_fpc = AW'(RST_PC);
    check();
    chk("rst_valid", 32'(INST_VALID), 32'd0);
    chk("rst_fpc", 32'(FETCH_PC), 32'(RST_PC));
    step();
    RESET_N = 1'b1;
    step();
    chk("postrst_valid", 32'(INST_VALID), 32'd1);
    chk("postrst_pc", 32'(INST_PC), 32'(RST_PC));
    chk("postrst_inst", 32'(INST_OUT), 32'h4800);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/prefetch_unit.md
PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 SHALL have parameter IW, default 15, instruction width in bits.
REQ-002 SHALL have parameter AW, default 8, address width; program memory depth is 2^AW words.
REQ-003 SHALL have parameter DEPTH, default 4, prefetch queue entries; power of 2, >=2.
REQ-004 SHALL have parameter RESET_PC, default 0, fetch address after reset.
REQ-005 SHALL have port CLK_FT  in  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port RESET_N  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port LD_EN  in  1  program-memory write strobe.
REQ-008 SHALL have port LD_ADDR  in  AW  program-memory write address.
REQ-009 SHALL have port LD_DATA  in  IW  program-memory write data.
REQ-010 SHALL have port HALT  in  1  suspend new fetches; queue keeps draining.
REQ-011 SHALL have port REDIR  in  1  branch/jump taken; flush and refetch.
REQ-012 SHALL have port REDIR_ADDR  in  AW  target address for REDIR.
REQ-013 SHALL have port INST_READY  in  1  consumer accepts head instruction.
REQ-014 SHALL have port INST_VALID  out  1  queue head holds a valid instruction.
REQ-015 SHALL have port INST_OUT  out  IW  head instruction word.
REQ-016 SHALL have port INST_PC  out  AW  address of head instruction.
REQ-017 SHALL have port FETCH_PC  out  AW  next address to be fetched.
REQ-018 SHALL have port Q_COUNT  out  clog2(DEPTH)+1  queue occupancy.

Function
REQ-019 SHALL implement a 2^AW x IW memory; LD_EN high writes LD_DATA to LD_ADDR at the clock edge.
REQ-020 SHALL implement a DEPTH-entry FIFO of {instruction, address} pairs.
REQ-021 Pop SHALL occur when INST_VALID and INST_READY are both high.
REQ-022 Issue SHALL occur when HALT=0, LD_EN=0, REDIR=0, and (Q_COUNT<DEPTH or pop this cycle).
REQ-023 On issue, mem[FETCH_PC] and FETCH_PC SHALL be written to the queue tail at that edge; the entry is visible at the head no earlier than the next cycle (1-cycle latency).
REQ-024 On issue, FETCH_PC SHALL increment by 1, wrapping 2^AW-1 -> 0.
REQ-025 Simultaneous issue and pop SHALL leave Q_COUNT unchanged, including when full.
REQ-026 REDIR high SHALL empty the queue, ignore any pop, and load FETCH_PC with REDIR_ADDR at the same edge; INST_VALID=0 next cycle.
REQ-027 After REDIR in cycle t (no HALT/LD_EN), the REDIR_ADDR instruction SHALL be issued in t+1 and valid at the head in t+2.
REQ-028 REDIR and LD_EN in the same cycle SHALL both take effect.
REQ-029 LD_EN SHALL NOT flush queued entries; stale entries remain until REDIR.
REQ-030 When Q_COUNT=0, INST_VALID, INST_OUT and INST_PC SHALL be 0.
REQ-031 HALT SHALL freeze FETCH_PC, with no issue, while pops continue.
REQ-032 Queue pointers SHALL wrap modulo DEPTH; Q_COUNT SHALL never exceed DEPTH or underflow.

Reset
REQ-033 RESET_N low SHALL immediately set FETCH_PC=RESET_PC, Q_COUNT=0, INST_VALID=0, INST_OUT=0, INST_PC=0, and empty pointers.
REQ-034 Memory contents SHALL NOT be affected by reset.
REQ-035 Reset asserted mid-operation SHALL discard all queued entries; issue resumes from RESET_PC in the first cycle after deassertion.

Verification
REQ-036 Load mem[0..15] with 15-bit program (0x4800, 0x4000, ...), reset, INST_READY=1 -> INST_PC sequence 0,1,2,... one per cycle after first valid, INST_OUT matching loaded words.
REQ-037 INST_READY=0 from reset -> Q_COUNT rises 1,2,3,4 and holds 4; FETCH_PC stops at 4; INST_PC=0.
REQ-038 Queue full, REDIR=1 with REDIR_ADDR=0x08 -> next cycle Q_COUNT=0, FETCH_PC=0x08; two cycles later INST_VALID=1, INST_PC=0x08.
REQ-039 FETCH_PC=0xFF, issue -> FETCH_PC=0x00, entry INST_PC=0xFF then 0x00.
REQ-040 HALT=1 with Q_COUNT=3, INST_READY=1 -> queue drains 3,2,1,0; FETCH_PC constant; INST_VALID=0 then.
REQ-041 RESET_N pulsed low with Q_COUNT=2 -> outputs 0 immediately, Q_COUNT=0, first issued address RESET_PC.
